// File: rtl/noc_pkg.sv
// Shared constants for the PE network interface: flit field offsets and drop counter sizing.
package noc_pkg;

    localparam int unsigned DROP_W = 16;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic int unsigned flit_pay_lsb();
        return 0;
    endfunction

    function automatic int unsigned flit_pay_msb(input int unsigned data_width);
        return data_width - 1;
    endfunction

    function automatic int unsigned flit_x_lsb(input int unsigned data_width);
        return data_width;
    endfunction

    function automatic int unsigned flit_y_lsb(input int unsigned data_width, input int unsigned x_size);
        return data_width + x_size;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads as zero while empty.
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic [WIDTH-1:0]             o_head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A full FIFO still takes a push when the same edge frees a slot.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push & ~w_do_pop)
                r_level <= r_level + LW'(1);
            else if (w_do_pop & ~w_do_push)
                r_level <= r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/noc_pe_interface.sv
// PE <-> router injection/ejection adapter: header pack/unpack, buffering,
// eject-side drop accounting and misroute detection.
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int unsigned X           = 2,
    parameter int unsigned Y           = 2,
    parameter int unsigned data_width  = 256,
    parameter int unsigned x_size      = 1,
    parameter int unsigned y_size      = 1,
    parameter int unsigned total_width = x_size + y_size + data_width,
    parameter int unsigned x_coord     = 0,
    parameter int unsigned y_coord     = 0,
    parameter int unsigned INJ_DEPTH   = 4,
    parameter int unsigned EJ_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [data_width-1:0]            s_data,
    input  logic [x_size-1:0]                s_dest_x,
    input  logic [y_size-1:0]                s_dest_y,
    output logic                             noc_valid_o,
    input  logic                             noc_ready_i,
    output logic [total_width-1:0]           noc_data_o,
    input  logic                             noc_valid_i,
    input  logic [total_width-1:0]           noc_data_i,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [data_width-1:0]            m_data,
    output logic [$clog2(INJ_DEPTH+1)-1:0]   inj_level,
    output logic [$clog2(EJ_DEPTH+1)-1:0]    ej_level,
    output logic [DROP_W-1:0]                drop_cnt,
    output logic                             misroute
);

    localparam int unsigned PAY_LSB = flit_pay_lsb();
    localparam int unsigned PAY_MSB = flit_pay_msb(data_width);
    localparam int unsigned X_LSB   = flit_x_lsb(data_width);
    localparam int unsigned Y_LSB   = flit_y_lsb(data_width, x_size);
    // Torus coordinates are taken modulo the mesh dimensions.
    localparam int unsigned MY_X    = x_coord % X;
    localparam int unsigned MY_Y    = y_coord % Y;

    logic                   w_inj_full;
    logic                   w_inj_empty;
    logic                   w_inj_push;
    logic                   w_inj_pop;
    logic [total_width-1:0] w_inj_din;
    logic [total_width-1:0] w_inj_head;

    logic                   w_ej_full;
    logic                   w_ej_empty;
    logic                   w_ej_pop;
    logic                   w_ej_drop;
    logic                   w_ej_off_node;
    logic [total_width-1:0] w_ej_head;
    logic                   w_unused_ej_hdr;

    logic [DROP_W-1:0]      r_drop_cnt;
    logic                   r_misroute;

    // Inject path
    assign w_inj_din  = {s_dest_y, s_dest_x, s_data};
    assign w_inj_push = s_valid & ~w_inj_full;
    assign w_inj_pop  = ~w_inj_empty & noc_ready_i;

    noc_sync_fifo #(
        .WIDTH (total_width),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_inj_push),
        .i_din   (w_inj_din),
        .i_pop   (w_inj_pop),
        .o_full  (w_inj_full),
        .o_empty (w_inj_empty),
        .o_level (inj_level),
        .o_head  (w_inj_head)
    );

    assign s_ready     = ~w_inj_full;
    assign noc_valid_o = ~w_inj_empty;
    assign noc_data_o  = w_inj_head;

    // Eject path: the router never stalls, so overflow is counted rather than back-pressured.
    assign w_ej_pop      = ~w_ej_empty & m_ready;
    assign w_ej_drop     = noc_valid_i & w_ej_full & ~w_ej_pop;
    assign w_ej_off_node = (noc_data_i[X_LSB +: x_size] != x_size'(MY_X)) |
                           (noc_data_i[Y_LSB +: y_size] != y_size'(MY_Y));

    noc_sync_fifo #(
        .WIDTH (total_width),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (noc_valid_i),
        .i_din   (noc_data_i),
        .i_pop   (w_ej_pop),
        .o_full  (w_ej_full),
        .o_empty (w_ej_empty),
        .o_level (ej_level),
        .o_head  (w_ej_head)
    );

    assign m_valid         = ~w_ej_empty;
    assign m_data          = w_ej_head[PAY_MSB:PAY_LSB];
    assign w_unused_ej_hdr = ^w_ej_head[total_width-1:data_width];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_drop_cnt <= '0;
            r_misroute <= 1'b0;
        end else begin
            if (w_ej_drop && (r_drop_cnt != DROP_MAX))
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            if (noc_valid_i && w_ej_off_node)
                r_misroute <= 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign misroute = r_misroute;

endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed bench for noc_pe_interface with a queue-based reference model checked every cycle.
module tb_noc_pe_interface;

    localparam int unsigned DW        = 256;
    localparam int unsigned TW        = DW + 2;
    localparam int unsigned INJ_DEPTH = 4;
    localparam int unsigned EJ_DEPTH  = 4;

    logic           clk;
    logic           rstn;
    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic [0:0]     s_dest_x;
    logic [0:0]     s_dest_y;
    logic           noc_valid_o;
    logic           noc_ready_i;
    logic [TW-1:0]  noc_data_o;
    logic           noc_valid_i;
    logic [TW-1:0]  noc_data_i;
    logic           m_valid;
    logic           m_ready;
    logic [DW-1:0]  m_data;
    logic [2:0]     inj_level;
    logic [2:0]     ej_level;
    logic [15:0]    drop_cnt;
    logic           misroute;

    noc_pe_interface dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_dest_x    (s_dest_x),
        .s_dest_y    (s_dest_y),
        .noc_valid_o (noc_valid_o),
        .noc_ready_i (noc_ready_i),
        .noc_data_o  (noc_data_o),
        .noc_valid_i (noc_valid_i),
        .noc_data_i  (noc_data_i),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .inj_level   (inj_level),
        .ej_level    (ej_level),
        .drop_cnt    (drop_cnt),
        .misroute    (misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: two bounded queues, a saturating drop count and a sticky misroute bit.
    logic [TW-1:0] inj_q[$];
    logic [TW-1:0] ej_q[$];
    int unsigned   m_drop;
    bit            m_mis;

    always @(posedge clk or negedge rstn) begin
        bit inj_room;
        bit ej_take;
        if (!rstn) begin
            inj_q.delete();
            ej_q.delete();
            m_drop = 0;
            m_mis  = 1'b0;
        end else begin
            inj_room = (inj_q.size() < INJ_DEPTH);
            if (inj_q.size() > 0 && noc_ready_i) void'(inj_q.pop_front());
            if (s_valid && inj_room) inj_q.push_back({s_dest_y, s_dest_x, s_data});

            ej_take = (ej_q.size() > 0) && m_ready;
            if (ej_take) void'(ej_q.pop_front());
            if (noc_valid_i) begin
                if (ej_q.size() < EJ_DEPTH) ej_q.push_back(noc_data_i);
                else if (m_drop < 16'hFFFF) m_drop = m_drop + 1;
                if (noc_data_i[TW-1] != 1'b0 || noc_data_i[TW-2] != 1'b0) m_mis = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("s_ready",     TW'(s_ready),     TW'(inj_q.size() < INJ_DEPTH));
        chk("noc_valid_o", TW'(noc_valid_o), TW'(inj_q.size() != 0));
        if (inj_q.size() != 0) chk("noc_data_o", noc_data_o, inj_q[0]);
        chk("m_valid",     TW'(m_valid),     TW'(ej_q.size() != 0));
        if (ej_q.size() != 0) chk("m_data", TW'(m_data), TW'(ej_q[0][DW-1:0]));
        chk("inj_level",   TW'(inj_level),   TW'(inj_q.size()));
        chk("ej_level",    TW'(ej_level),    TW'(ej_q.size()));
        chk("drop_cnt",    TW'(drop_cnt),    TW'(m_drop));
        chk("misroute",    TW'(misroute),    TW'(m_mis));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        s_valid     = 1'b0;
        s_data      = '0;
        s_dest_x    = '0;
        s_dest_y    = '0;
        noc_ready_i = 1'b0;
        noc_valid_i = 1'b0;
        noc_data_i  = '0;
        m_ready     = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("rst s_ready",     TW'(s_ready),     TW'(1));
        chk("rst noc_valid_o", TW'(noc_valid_o), TW'(0));
        chk("rst m_valid",     TW'(m_valid),     TW'(0));
        chk("rst drop_cnt",    TW'(drop_cnt),    TW'(0));

        // Single inject to (1,1)
        s_valid = 1'b1; s_data = 256'hA5; s_dest_x = 1'b1; s_dest_y = 1'b1; noc_ready_i = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("inj1 valid", TW'(noc_valid_o), TW'(1));
        chk("inj1 data",  noc_data_o, {1'b1, 1'b1, 256'hA5});
        tick();
        chk("inj1 popped", TW'(noc_valid_o), TW'(0));

        // Inject stall: five offers into a four-deep FIFO
        noc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid  = 1'b1;
            s_data   = DW'(16 + i);
            s_dest_x = 1'(i);
            s_dest_y = 1'(i >> 1);
            tick();
        end
        s_valid = 1'b0;
        chk("stall level", TW'(inj_level), TW'(4));
        chk("stall ready", TW'(s_ready),   TW'(0));
        chk("stall head",  noc_data_o, {1'b0, 1'b0, 256'h10});
        noc_ready_i = 1'b1;
        tick();
        chk("stall 2nd", noc_data_o, {1'b0, 1'b1, 256'h11});
        tick(); tick(); tick();
        chk("stall drained", TW'(inj_level), TW'(0));
        noc_ready_i = 1'b0;

        // Eject overflow: six arrivals, nobody draining
        for (int i = 0; i < 6; i++) begin
            noc_valid_i = 1'b1;
            noc_data_i  = {1'b0, 1'b0, DW'(32 + i)};
            tick();
        end
        noc_valid_i = 1'b0;
        chk("ovf level", TW'(ej_level), TW'(4));
        chk("ovf drops", TW'(drop_cnt), TW'(2));
        chk("ovf head",  TW'(m_data),   TW'(32));
        chk("ovf mis",   TW'(misroute), TW'(0));

        // Full with simultaneous pop: push accepted, no drop
        m_ready = 1'b1; noc_valid_i = 1'b1; noc_data_i = {1'b0, 1'b0, 256'h30};
        tick();
        m_ready = 1'b0; noc_valid_i = 1'b0;
        chk("fullpop level", TW'(ej_level), TW'(4));
        chk("fullpop drops", TW'(drop_cnt), TW'(2));
        chk("fullpop head",  TW'(m_data),   TW'(33));
        m_ready = 1'b1;
        tick(); tick(); tick(); tick();
        m_ready = 1'b0;
        chk("ej drained", TW'(m_valid), TW'(0));

        // Misroute: dest (1,0) arriving at node (0,0)
        noc_valid_i = 1'b1; noc_data_i = {1'b0, 1'b1, 256'h77};
        tick();
        noc_valid_i = 1'b0;
        chk("mis flag",  TW'(misroute), TW'(1));
        chk("mis valid", TW'(m_valid),  TW'(1));
        chk("mis data",  TW'(m_data),   TW'(256'h77));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Full-rate streaming in both directions
        noc_ready_i = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_valid     = 1'b1;
            s_data      = DW'(64 + i);
            s_dest_x    = 1'(i);
            s_dest_y    = 1'(~i);
            noc_valid_i = 1'b1;
            noc_data_i  = {1'b0, 1'b0, DW'(80 + i)};
            tick();
        end
        s_valid = 1'b0; noc_valid_i = 1'b0;
        chk("stream inj level", TW'(inj_level), TW'(1));
        chk("stream ej level",  TW'(ej_level),  TW'(1));
        tick(); tick();
        noc_ready_i = 1'b0; m_ready = 1'b0;

        // Reset with three flits buffered on each side
        for (int i = 0; i < 3; i++) begin
            s_valid     = 1'b1;
            s_data      = DW'(96 + i);
            noc_valid_i = 1'b1;
            noc_data_i  = {1'b0, 1'b0, DW'(112 + i)};
            tick();
        end
        idle_inputs();
        chk("pre-rst inj level", TW'(inj_level), TW'(3));
        chk("pre-rst ej level",  TW'(ej_level),  TW'(3));
        #1;
        rstn = 1'b0;
        #1;
        chk("mid-rst s_ready",     TW'(s_ready),     TW'(1));
        chk("mid-rst noc_valid_o", TW'(noc_valid_o), TW'(0));
        chk("mid-rst noc_data_o",  noc_data_o,       TW'(0));
        chk("mid-rst m_valid",     TW'(m_valid),     TW'(0));
        chk("mid-rst m_data",      TW'(m_data),      TW'(0));
        chk("mid-rst inj_level",   TW'(inj_level),   TW'(0));
        chk("mid-rst ej_level",    TW'(ej_level),    TW'(0));
        chk("mid-rst drop_cnt",    TW'(drop_cnt),    TW'(0));
        chk("mid-rst misroute",    TW'(misroute),    TW'(0));
        tick();
        rstn = 1'b1;
        tick();
        chk("post-rst s_ready",   TW'(s_ready),   TW'(1));
        chk("post-rst inj_level", TW'(inj_level), TW'(0));
        chk("post-rst ej_level",  TW'(ej_level),  TW'(0));
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
